fb_writer: RTL

Framebuffer write stage that sits directly upstream of the VGA scanout. It accepts the raytracer's pixel stream in raster order over a valid/ready handshake and turns it into sequential writes to the write port of the dual-port frame RAM. The scanout reads the other port at address x + y*640. This block places pixel (x, y) at exactly that address, one 24-bit word per pixel, and reports frame completion.

---
 rtl/fb_pkg.sv | 11 +
 rtl/fb_writer_skid_buffer.sv | 57 +++++
 rtl/fb_writer.sv | 115 +++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Frame geometry and pixel format shared by the framebuffer writer and the scanout.
package fb_pkg;
  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int FB_PIXELS = H_RES * V_RES;
  localparam int ADDR_W    = 19;
  localparam int DATA_W    = 24;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
endpackage

// File: rtl/fb_writer_skid_buffer.sv
// Two-entry skid buffer: the output registers are the main stage and one skid
// register absorbs a word accepted while the output is stalled.
module skid_buffer #(
  parameter int DATA_W = fb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_allow,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data
);
  logic              r_ready;
  logic              r_out_valid;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [DATA_W-1:0] r_skid_data;
  logic              w_in_fire;
  logic              w_out_load;
  logic              w_skid_valid_nxt;

  assign w_in_fire        = i_valid && r_ready;
  assign w_out_load       = !r_out_valid || i_ready;
  assign w_skid_valid_nxt = !w_out_load && (r_skid_valid || w_in_fire);

  // ready is registered, so it is derived from next-cycle occupancy and i_allow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready      <= 1'b0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out_data   <= '0;
      r_skid_data  <= '0;
    end else begin
      r_ready      <= i_allow && !w_skid_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      if (w_out_load) begin
        r_out_valid <= r_skid_valid || w_in_fire;
      end
      if (w_out_load && r_skid_valid) begin
        r_out_data <= r_skid_data;
      end else if (w_out_load && w_in_fire) begin
        r_out_data <= i_data;
      end
      if (!w_out_load && w_in_fire) begin
        r_skid_data <= i_data;
      end
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;
endmodule

// File: rtl/fb_writer.sv
// Raster pixel stream to sequential frame-RAM writes at x + y*H_RES.
// States: IDLE waits for FRAME_START | RUN accepts pixels until the last write is granted.
module fb_writer #(
  parameter int H_RES  = fb_pkg::H_RES,
  parameter int V_RES  = fb_pkg::V_RES,
  parameter int ADDR_W = fb_pkg::ADDR_W,
  parameter int DATA_W = fb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              FRAME_START,
  input  logic              PIX_VALID,
  output logic              PIX_READY,
  input  logic [DATA_W-1:0] PIX_DATA,
  output logic [9:0]        PIX_X,
  output logic [9:0]        PIX_Y,
  output logic              WR_EN,
  input  logic              WR_READY,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  output logic              BUSY,
  output logic              FRAME_DONE
);
  import fb_pkg::*;

  localparam int              FRAME_PIX = H_RES * V_RES;
  localparam logic [ADDR_W:0] CNT_FULL  = (ADDR_W + 1)'(FRAME_PIX);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);
  localparam logic [9:0]      X_LAST    = 10'(H_RES - 1);

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [ADDR_W:0]   r_acc_cnt;
  logic [ADDR_W:0]   w_acc_cnt_nxt;
  logic [9:0]        r_x;
  logic [9:0]        r_y;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_frame_done;
  logic              w_start;
  logic              w_accept;
  logic              w_wr_done;
  logic              w_last_wr;
  logic              w_allow;

  assign w_accept  = PIX_VALID && PIX_READY;
  assign w_wr_done = WR_EN && WR_READY;
  assign w_last_wr = (r_state == RUN) && w_wr_done && (r_wr_addr == LAST_ADDR);
  // a start coinciding with the done pulse is dropped; it must come again in IDLE
  assign w_start   = (r_state == IDLE) && FRAME_START && !r_frame_done;

  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = RUN;
    end else if (w_last_wr) begin
      w_state_nxt = IDLE;
    end
  end

  assign w_acc_cnt_nxt = w_start  ? '0 :
                         w_accept ? r_acc_cnt + CNT_ONE : r_acc_cnt;
  assign w_allow       = (w_state_nxt == RUN) && (w_acc_cnt_nxt < CNT_FULL);

  skid_buffer #(.DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_allow (w_allow),
    .i_valid (PIX_VALID),
    .o_ready (PIX_READY),
    .i_data  (PIX_DATA),
    .o_valid (WR_EN),
    .i_ready (WR_READY),
    .o_data  (WR_DATA)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_acc_cnt    <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_wr_addr    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_acc_cnt    <= w_acc_cnt_nxt;
      r_frame_done <= w_last_wr;
      if (w_start) begin
        r_x       <= '0;
        r_y       <= '0;
        r_wr_addr <= '0;
      end else begin
        // coordinates park on the last pixel once the frame is fully accepted
        if (w_accept && (w_acc_cnt_nxt != CNT_FULL)) begin
          if (r_x == X_LAST) begin
            r_x <= '0;
            r_y <= r_y + 10'd1;
          end else begin
            r_x <= r_x + 10'd1;
          end
        end
        if (w_wr_done) begin
          r_wr_addr <= r_wr_addr + ADDR_W'(1);
        end
      end
    end
  end

  assign PIX_X      = r_x;
  assign PIX_Y      = r_y;
  assign WR_ADDR    = r_wr_addr;
  assign BUSY       = (r_state == RUN);
  assign FRAME_DONE = r_frame_done;
endmodule
